// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical register tags feeding dispatch, refilled by retire.
// Optional same-cycle enqueue-to-dequeue bypass when empty: define FREE_LIST_BYPASS_EN.
module phys_reg_free_list #(
  parameter int unsigned NUM_PHYS_REGS = 64,
  parameter int unsigned NUM_ARCH_REGS = 32,
  localparam int LOG_PHYS_REGS = $clog2(NUM_PHYS_REGS),
  localparam int DEPTH         = int'(NUM_PHYS_REGS - NUM_ARCH_REGS),
  localparam int PTR_W         = $clog2(DEPTH) + 1
) (
  input  logic                     CLK,
  input  logic                     nRST,
  output logic                     DUT_error,
  input  logic                     dequeue_req,
  output logic                     dequeue_valid,
  output logic [LOG_PHYS_REGS-1:0] dequeue_phys_reg_tag,
  input  logic                     enqueue_valid,
  input  logic [LOG_PHYS_REGS-1:0] enqueue_phys_reg_tag,
  output logic [PTR_W-1:0]         head_checkpoint,
  input  logic                     revert_valid,
  input  logic [PTR_W-1:0]         revert_head_checkpoint,
  output logic [PTR_W-1:0]         free_count,
  output logic                     empty,
  output logic                     full
);

  localparam int IDX_W = PTR_W - 1;

  logic [LOG_PHYS_REGS-1:0] entry_q [DEPTH];
  logic [PTR_W-1:0]         head_q, head_d;
  logic [PTR_W-1:0]         tail_q, tail_d;
  logic                     err_q, err_d;

  logic [IDX_W-1:0] head_idx, tail_idx;
  logic             enq_ok;
  logic             deq_fire;
  logic             revert_err;

  // Index wraps at DEPTH (not a power of two in general); wrap bit toggles on wrap.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [IDX_W-1:0] idx;
    idx = p[IDX_W-1:0];
    if (idx == IDX_W'(DEPTH - 1)) begin
      ptr_inc = {~p[PTR_W-1], {IDX_W{1'b0}}};
    end else begin
      ptr_inc = {p[PTR_W-1], idx + IDX_W'(1)};
    end
  endfunction

  // a - b in the 2*DEPTH pointer space.
  function automatic int ptr_dist(input logic [PTR_W-1:0] a, input logic [PTR_W-1:0] b);
    int d;
    d = int'(a[IDX_W-1:0]) - int'(b[IDX_W-1:0]);
    if (a[PTR_W-1] != b[PTR_W-1]) d = d + DEPTH;
    if (d < 0) d = d + 2 * DEPTH;
    return d;
  endfunction

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];

  assign empty      = (head_q == tail_q);
  assign full       = (head_idx == tail_idx) && (head_q[PTR_W-1] != tail_q[PTR_W-1]);
  assign free_count = PTR_W'(ptr_dist(tail_q, head_q));

  assign head_checkpoint = head_q;
  assign DUT_error       = err_q;

  // Full is judged on registered state only, so a same-cycle dequeue does not make room.
  assign enq_ok = enqueue_valid && !full && (enqueue_phys_reg_tag != '0);

`ifdef FREE_LIST_BYPASS_EN
  logic bypass;
  assign bypass               = empty && enq_ok && !revert_valid;
  assign dequeue_valid        = !empty || bypass;
  assign dequeue_phys_reg_tag = bypass ? enqueue_phys_reg_tag : entry_q[head_idx];
`else
  assign dequeue_valid        = !empty;
  assign dequeue_phys_reg_tag = entry_q[head_idx];
`endif

  assign deq_fire   = dequeue_req && dequeue_valid && !revert_valid;
  assign revert_err = revert_valid && (ptr_dist(tail_q, revert_head_checkpoint) > DEPTH);

  always_comb begin
    head_d = head_q;
    if (revert_valid) begin
      head_d = revert_head_checkpoint;
    end else if (deq_fire) begin
      head_d = ptr_inc(head_q);
    end
  end

  always_comb begin
    tail_d = tail_q;
    if (enq_ok) tail_d = ptr_inc(tail_q);
  end

  always_comb begin
    err_d = 1'b0;
    if (enqueue_valid && (full || (enqueue_phys_reg_tag == '0))) err_d = 1'b1;
    if (revert_err) err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q <= '0;
      tail_q <= {1'b1, {IDX_W{1'b0}}};
      err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= LOG_PHYS_REGS'(NUM_ARCH_REGS + 32'(i));
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      err_q  <= err_d;
      if (enq_ok) entry_q[tail_idx] <= enqueue_phys_reg_tag;
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed table-driven bench for phys_reg_free_list (default 64 phys / 32 arch regs).
module tb_phys_reg_free_list;

`ifdef FREE_LIST_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       DUT_error;
  logic       dequeue_req = 1'b0;
  logic       dequeue_valid;
  logic [5:0] dequeue_phys_reg_tag;
  logic       enqueue_valid = 1'b0;
  logic [5:0] enqueue_phys_reg_tag = '0;
  logic [5:0] head_checkpoint;
  logic       revert_valid = 1'b0;
  logic [5:0] revert_head_checkpoint = '0;
  logic [5:0] free_count;
  logic       empty;
  logic       full;

  always #5 CLK = ~CLK;

  phys_reg_free_list dut (
    .CLK                    (CLK),
    .nRST                   (nRST),
    .DUT_error              (DUT_error),
    .dequeue_req            (dequeue_req),
    .dequeue_valid          (dequeue_valid),
    .dequeue_phys_reg_tag   (dequeue_phys_reg_tag),
    .enqueue_valid          (enqueue_valid),
    .enqueue_phys_reg_tag   (enqueue_phys_reg_tag),
    .head_checkpoint        (head_checkpoint),
    .revert_valid           (revert_valid),
    .revert_head_checkpoint (revert_head_checkpoint),
    .free_count             (free_count),
    .empty                  (empty),
    .full                   (full)
  );

  typedef struct {
    bit         rst;
    bit         req;
    bit         ev;
    logic [5:0] etag;
    bit         rv;
    logic [5:0] rck;
    bit         xv;
    bit         chk;
    logic [5:0] xtag;
    logic [5:0] xcnt;
    bit         xe;
    bit         xf;
    bit         xerr;
    logic [5:0] xhead;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic void add(bit rst, bit req, bit ev, int etag, bit rv, int rck, bit xv,
                              bit chk, int xtag, int xcnt, bit xe, bit xf, bit xerr,
                              int xhead);
    vec_t v;
    v.rst = rst; v.req = req; v.ev = ev; v.etag = 6'(etag); v.rv = rv; v.rck = 6'(rck);
    v.xv = xv; v.chk = chk; v.xtag = 6'(xtag); v.xcnt = 6'(xcnt);
    v.xe = xe; v.xf = xf; v.xerr = xerr; v.xhead = 6'(xhead);
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, then drain all 32 free tags; extra requests on empty are no-ops.
    add(1, 0, 0, 0, 0, 0, 1, 1, 32, 32, 0, 1, 0, 0);
    for (int i = 0; i < 32; i++) add(0, 1, 0, 0, 0, 0, 1, 1, 32 + i, 32 - i, 0, i == 0, 0, i);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32);
    add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32);
    // Refill 40,7,55 from empty and drain them back in order.
    add(0, 0, 1, 40, 0, 0, BYP, BYP, 40, 0, 1, 0, 0, 32);
    add(0, 0, 1, 7, 0, 0, 1, 1, 40, 1, 0, 0, 0, 32);
    add(0, 0, 1, 55, 0, 0, 1, 1, 40, 2, 0, 0, 0, 32);
    add(0, 1, 0, 0, 0, 0, 1, 1, 40, 3, 0, 0, 0, 32);
    add(0, 1, 0, 0, 0, 0, 1, 1, 7, 2, 0, 0, 0, 33);
    add(0, 1, 0, 0, 0, 0, 1, 1, 55, 1, 0, 0, 0, 34);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 35);
    // Async reset mid-operation, checkpoint at 5, dequeue 4, revert with deq+enq of 9.
    for (int i = 0; i < 5; i++) add(i == 0, 1, 0, 0, 0, 0, 1, 1, 32 + i, 32 - i, 0, i == 0, 0, i);
    add(0, 0, 0, 0, 0, 0, 1, 1, 37, 27, 0, 0, 0, 5);
    for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 0, 1, 1, 37 + i, 27 - i, 0, 0, 0, 5 + i);
    add(0, 1, 1, 9, 1, 5, 1, 1, 41, 23, 0, 0, 0, 9);
    add(0, 0, 0, 0, 0, 0, 1, 1, 37, 28, 0, 0, 0, 5);
    // Tag 0 enqueue: dropped, error for exactly one cycle.
    add(0, 0, 1, 0, 0, 0, 1, 1, 37, 28, 0, 0, 0, 5);
    add(0, 0, 0, 0, 0, 0, 1, 1, 37, 28, 0, 0, 1, 5);
    add(0, 0, 0, 0, 0, 0, 1, 1, 37, 28, 0, 0, 0, 5);
    // Enqueue while full, alone and with a same-cycle dequeue.
    add(1, 0, 1, 20, 0, 0, 1, 1, 32, 32, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 32, 32, 0, 1, 1, 0);
    add(0, 1, 1, 21, 0, 0, 1, 1, 32, 32, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1, 33, 31, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1, 1, 33, 31, 0, 0, 0, 1);
    // Out-of-range revert: error, head still loaded; then a legal revert back.
    add(0, 0, 0, 0, 1, 33, 1, 1, 33, 31, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 1, 33, 63, 0, 0, 1, 33);
    add(0, 0, 0, 0, 1, 1, 1, 1, 33, 63, 0, 0, 0, 33);
    add(0, 0, 0, 0, 0, 0, 1, 1, 33, 31, 0, 0, 0, 1);
    // Empty + enqueue 12 + dequeue_req in the same cycle.
    for (int i = 0; i < 32; i++) add(i == 0, 1, 0, 0, 0, 0, 1, 1, 32 + i, 32 - i, 0, i == 0, 0, i);
    add(0, 1, 1, 12, 0, 0, BYP, BYP, 12, 0, 1, 0, 0, 32);
    if (BYP) begin
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 33);
      add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 33);
    end else begin
      add(0, 0, 0, 0, 0, 0, 1, 1, 12, 1, 0, 0, 0, 32);
      add(0, 1, 0, 0, 0, 0, 1, 1, 12, 1, 0, 0, 0, 32);
    end
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 33);

    foreach (vecs[i]) begin
      @(negedge CLK);
      if (vecs[i].rst) begin
        nRST = 1'b0;
        #1;
        nRST = 1'b1;
      end
      dequeue_req            = vecs[i].req;
      enqueue_valid          = vecs[i].ev;
      enqueue_phys_reg_tag   = vecs[i].etag;
      revert_valid           = vecs[i].rv;
      revert_head_checkpoint = vecs[i].rck;
      #1;
      chk("dequeue_valid", i, int'(dequeue_valid), int'(vecs[i].xv));
      if (vecs[i].chk) chk("tag", i, int'(dequeue_phys_reg_tag), int'(vecs[i].xtag));
      chk("free_count", i, int'(free_count), int'(vecs[i].xcnt));
      chk("empty", i, int'(empty), int'(vecs[i].xe));
      chk("full", i, int'(full), int'(vecs[i].xf));
      chk("DUT_error", i, int'(DUT_error), int'(vecs[i].xerr));
      chk("head_checkpoint", i, int'(head_checkpoint), int'(vecs[i].xhead));
    end

    // Held reset ignores traffic across several edges.
    @(negedge CLK);
    nRST                 = 1'b0;
    dequeue_req          = 1'b1;
    enqueue_valid        = 1'b1;
    enqueue_phys_reg_tag = 6'd5;
    revert_valid         = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      chk("hold_rst.count", k, int'(free_count), 32);
      chk("hold_rst.head", k, int'(head_checkpoint), 0);
      chk("hold_rst.err", k, int'(DUT_error), 0);
    end
    @(negedge CLK);
    nRST          = 1'b1;
    dequeue_req   = 1'b0;
    enqueue_valid = 1'b0;
    #1;
    chk("post_rst.tag", 0, int'(dequeue_phys_reg_tag), 32);
    chk("post_rst.full", 0, int'(full), 1);
    @(negedge CLK);
    dequeue_req = 1'b1;
    @(negedge CLK);
    dequeue_req = 1'b0;
    #1;
    chk("post_rst.head", 1, int'(head_checkpoint), 1);
    chk("post_rst.tag", 1, int'(dequeue_phys_reg_tag), 33);
    chk("post_rst.count", 1, int'(free_count), 31);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
